rom_angle_burst_arbiter: RTL and testbench

- Shares one synchronous-read angle ROM (1-cycle read latency, enable-gated output register) between two requesters.
- Each requester asks for a burst: a start index and a word count. The block grants bursts round-robin and sequences ROM addresses with modular wrap.
- Returned words go out on a single valid/ready stream tagged with the requester id.
- Sits between the angle ROM instance and the sampler/transform engines that consume angle constants.

---
 rtl/rom_angle_pkg.sv | 29 ++
 rtl/rom_angle_skid_buf.sv | 81 ++++++++
 rtl/rom_angle_burst_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_rom_angle_burst_arbiter.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_angle_pkg.sv
// rom_angle_pkg: shared types and defaults for the angle ROM burst arbiter.
// Holds the FSM state enum, requester id type, default geometry and the
// width of the optional performance counters (ROM_ANGLE_ARB_PERF_EN).
package rom_angle_pkg;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    // One bit is enough to name either of the two requesters
    typedef logic req_id_t;

    // Default ROM geometry and burst limit
    localparam int DEF_MEM_WIDTH = 16;
    localparam int DEF_MEM_DEPTH = 20;
    localparam int DEF_MAX_BURST = 32;

    // Width of each optional performance counter
    localparam int PERF_W = 16;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] value);
        return (value == {PERF_W{1'b1}}) ? value : value + PERF_W'(1);
    endfunction

endpackage

// File: rtl/rom_angle_skid_buf.sv
// rom_angle_skid_buf: two-entry FIFO of {data, id, last} words returned by
// the angle ROM. Slot 0 is always the head, so the head outputs come straight
// from registers; slot 1 shifts into slot 0 on a pop.
module rom_angle_skid_buf
    import rom_angle_pkg::*;
#(
    parameter int WIDTH = DEF_MEM_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  req_id_t          push_id,
    input  logic             push_last,
    input  logic             pop,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output req_id_t          head_id,
    output logic             head_last,
    output logic [1:0]       occupancy
);

    logic [WIDTH-1:0] data0_reg, data1_reg;
    req_id_t          id0_reg, id1_reg;
    logic             last0_reg, last1_reg;
    logic             valid0_reg, valid1_reg;

    logic             pop_ok;
    logic             push_ok;
    logic [1:0]       count_after_pop;
    logic [1:0]       count_next;
    logic             land_in_slot0;

    // A pop needs a head; a push needs a free slot once this cycle's pop is applied.
    assign pop_ok  = pop && valid0_reg;
    assign push_ok = push && (!valid1_reg || pop_ok);

    assign occupancy       = {1'b0, valid0_reg} + {1'b0, valid1_reg};
    assign count_after_pop = occupancy - {1'b0, pop_ok};
    assign count_next      = count_after_pop + {1'b0, push_ok};
    assign land_in_slot0   = (count_after_pop == 2'd0);

    // Slot update: push lands in the first slot free after the pop; pop shifts slot 1 down.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data0_reg  <= '0;
            data1_reg  <= '0;
            id0_reg    <= 1'b0;
            id1_reg    <= 1'b0;
            last0_reg  <= 1'b0;
            last1_reg  <= 1'b0;
            valid0_reg <= 1'b0;
            valid1_reg <= 1'b0;
        end else begin
            if (push_ok && land_in_slot0) begin
                data0_reg <= push_data;
                id0_reg   <= push_id;
                last0_reg <= push_last;
            end else if (pop_ok) begin
                data0_reg <= data1_reg;
                id0_reg   <= id1_reg;
                last0_reg <= last1_reg;
            end

            if (push_ok && !land_in_slot0) begin
                data1_reg <= push_data;
                id1_reg   <= push_id;
                last1_reg <= push_last;
            end

            valid0_reg <= (count_next != 2'd0);
            valid1_reg <= (count_next == 2'd2);
        end
    end

    assign head_valid = valid0_reg;
    assign head_data  = data0_reg;
    assign head_id    = id0_reg;
    assign head_last  = last0_reg;

endmodule

// File: rtl/rom_angle_burst_arbiter.sv
// rom_angle_burst_arbiter: shares one synchronous-read angle ROM between two
// burst requesters. Bursts are granted round-robin, ROM addresses wrap modulo
// MEM_DEPTH, and returned words leave on one valid/ready stream tagged with
// the owning requester. Reads are only issued when the two-entry return
// buffer is guaranteed to have room, so backpressure never drops a word.
// Optional macro ROM_ANGLE_ARB_PERF_EN adds saturating grant/stall counters.
module rom_angle_burst_arbiter
    import rom_angle_pkg::*;
#(
    parameter int  MEM_WIDTH = DEF_MEM_WIDTH,
    parameter int  MEM_DEPTH = DEF_MEM_DEPTH,
    parameter int  MAX_BURST = DEF_MAX_BURST,
    localparam int ADDR_W    = $clog2(MEM_DEPTH),
    localparam int LEN_W     = $clog2(MAX_BURST + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [2*ADDR_W-1:0]   req_start,
    input  logic [2*LEN_W-1:0]    req_len,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [MEM_WIDTH-1:0]  out_data,
    output logic                  out_id,
    output logic                  out_last,
    output logic                  busy,
    output logic                  rom_enable,
    output logic [ADDR_W-1:0]     rom_address,
    input  logic [MEM_WIDTH-1:0]  rom_dout
`ifdef ROM_ANGLE_ARB_PERF_EN
    ,
    output logic [PERF_W-1:0]     perf_grants0,
    output logic [PERF_W-1:0]     perf_grants1,
    output logic [PERF_W-1:0]     perf_stall
`endif
);

    state_t            state_reg;
    req_id_t           rr_reg;
    req_id_t           id_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [LEN_W-1:0]  remaining_reg;
    logic              busy_reg;
    logic              inflight_reg;
    logic              last_inflight_reg;

    logic [ADDR_W-1:0] start_slice [2];
    logic [LEN_W-1:0]  len_slice   [2];

    logic              grant_any;
    req_id_t           grant_id;
    logic [ADDR_W-1:0] sel_start;
    logic [LEN_W-1:0]  sel_len;
    logic [ADDR_W-1:0] start_norm;
    logic [LEN_W-1:0]  len_clamped;
    logic [ADDR_W-1:0] addr_next;

    logic              pop;
    logic              issue;
    logic [1:0]        occupancy;
    logic [2:0]        in_use;
    logic [2:0]        in_use_limit;

    logic              buf_valid;
    logic [MEM_WIDTH-1:0] buf_data;
    req_id_t           buf_id;
    logic              buf_last;

    // Per-requester request fields and the combinational acceptance pulse.
    // Ready is masked during reset so every output reads 0 while it is held.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            assign start_slice[gi] = req_start[gi*ADDR_W +: ADDR_W];
            assign len_slice[gi]   = req_len[gi*LEN_W +: LEN_W];
            assign req_ready[gi]   = grant_any && (grant_id == req_id_t'(gi)) && !reset;
        end
    endgenerate

    // Round-robin pick: the pointed-to requester wins, otherwise the other one.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = rr_reg;
        if (state_reg == IDLE) begin
            if (req_valid[rr_reg]) begin
                grant_any = 1'b1;
                grant_id  = rr_reg;
            end else if (req_valid[~rr_reg]) begin
                grant_any = 1'b1;
                grant_id  = ~rr_reg;
            end
        end
    end

    // Out-of-range starts fold back once; over-long bursts are clamped.
    assign sel_start   = start_slice[grant_id];
    assign sel_len     = len_slice[grant_id];
    assign start_norm  = (int'(sel_start) >= MEM_DEPTH) ? sel_start - ADDR_W'(MEM_DEPTH) : sel_start;
    assign len_clamped = (int'(sel_len) > MAX_BURST) ? LEN_W'(MAX_BURST) : sel_len;
    assign addr_next   = (addr_reg == ADDR_W'(MEM_DEPTH - 1)) ? '0 : addr_reg + ADDR_W'(1);

    // Issue only if the words already buffered or in flight, less the one
    // leaving this cycle, leave room for one more. This path is combinational
    // from out_ready so full throughput is kept with a single-cycle ROM.
    assign pop          = buf_valid && out_ready;
    assign in_use       = {1'b0, occupancy} + {2'b00, inflight_reg};
    assign in_use_limit = 3'd2 + {2'b00, pop};
    assign issue        = (state_reg == STREAM) && (remaining_reg != '0) && (in_use < in_use_limit);

    assign rom_enable  = issue;
    assign rom_address = addr_reg;

    // Burst sequencer: latch a grant, walk the addresses, wait for the buffer to empty.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            rr_reg        <= 1'b0;
            id_reg        <= 1'b0;
            addr_reg      <= '0;
            remaining_reg <= '0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_any) begin
                        id_reg        <= grant_id;
                        addr_reg      <= start_norm;
                        remaining_reg <= len_clamped;
                        if (len_clamped == '0) begin
                            rr_reg <= ~grant_id;
                        end else begin
                            state_reg <= STREAM;
                            busy_reg  <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (issue) begin
                        addr_reg      <= addr_next;
                        remaining_reg <= remaining_reg - LEN_W'(1);
                        if (remaining_reg == LEN_W'(1)) begin
                            state_reg <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if ((occupancy == 2'd0) && !inflight_reg) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        rr_reg    <= ~id_reg;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Track the read in flight so its result is captured the next cycle with its last flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inflight_reg      <= 1'b0;
            last_inflight_reg <= 1'b0;
        end else begin
            inflight_reg      <= issue;
            last_inflight_reg <= issue && (remaining_reg == LEN_W'(1));
        end
    end

    rom_angle_skid_buf #(
        .WIDTH (MEM_WIDTH)
    ) u_skid_buf (
        .clock      (clock),
        .reset      (reset),
        .push       (inflight_reg),
        .push_data  (rom_dout),
        .push_id    (id_reg),
        .push_last  (last_inflight_reg),
        .pop        (pop),
        .head_valid (buf_valid),
        .head_data  (buf_data),
        .head_id    (buf_id),
        .head_last  (buf_last),
        .occupancy  (occupancy)
    );

    assign out_valid = buf_valid;
    assign out_data  = buf_data;
    assign out_id    = buf_id;
    assign out_last  = buf_last;
    assign busy      = busy_reg;

`ifdef ROM_ANGLE_ARB_PERF_EN
    logic [PERF_W-1:0] perf_grants0_reg;
    logic [PERF_W-1:0] perf_grants1_reg;
    logic [PERF_W-1:0] perf_stall_reg;

    // Saturating counters for non-empty grants per requester and output stalls.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_grants0_reg <= '0;
            perf_grants1_reg <= '0;
            perf_stall_reg   <= '0;
        end else begin
            if (grant_any && (len_clamped != '0)) begin
                if (grant_id == 1'b0) begin
                    perf_grants0_reg <= sat_inc(perf_grants0_reg);
                end else begin
                    perf_grants1_reg <= sat_inc(perf_grants1_reg);
                end
            end
            if (buf_valid && !out_ready) begin
                perf_stall_reg <= sat_inc(perf_stall_reg);
            end
        end
    end

    assign perf_grants0 = perf_grants0_reg;
    assign perf_grants1 = perf_grants1_reg;
    assign perf_stall   = perf_stall_reg;
`endif

endmodule

// File: tb/tb_rom_angle_burst_arbiter.sv
// tb_rom_angle_burst_arbiter: directed and randomized bench for the angle ROM
// burst arbiter, with a queue-based reference model of grants, addresses and
// returned words, plus literal expectations for the documented scenarios.
module tb_rom_angle_burst_arbiter;

    localparam int AW    = 5;
    localparam int LW    = 6;
    localparam int DEPTH = 20;
    localparam int MAXB  = 32;

    typedef struct packed {
        logic        id;
        logic [15:0] data;
        logic        last;
    } word_t;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [1:0]        req_valid = 2'b00;
    logic [1:0]        req_ready;
    logic [2*AW-1:0]   req_start = '0;
    logic [2*LW-1:0]   req_len = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [15:0]       out_data;
    logic              out_id;
    logic              out_last;
    logic              busy;
    logic              rom_enable;
    logic [AW-1:0]     rom_address;
    logic [15:0]       rom_dout = '0;
`ifdef ROM_ANGLE_ARB_PERF_EN
    logic [15:0]       perf_grants0, perf_grants1, perf_stall;
`endif

    logic [15:0] rom_mem [DEPTH] = '{
        16'h1fdf, 16'h1bff, 16'h1c3f, 16'h02df, 16'h0fcf,
        16'h0b4f, 16'h0fff, 16'h0d21, 16'h2a7c, 16'h3e10,
        16'h4c8b, 16'h5a03, 16'h6f4e, 16'h7b19, 16'h8c55,
        16'h9e02, 16'ha6f1, 16'hc3d8, 16'hf3cf, 16'h1b4f
    };

    rom_angle_burst_arbiter dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_start   (req_start),
        .req_len     (req_len),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_id      (out_id),
        .out_last    (out_last),
        .busy        (busy),
        .rom_enable  (rom_enable),
        .rom_address (rom_address),
        .rom_dout    (rom_dout)
`ifdef ROM_ANGLE_ARB_PERF_EN
        ,
        .perf_grants0 (perf_grants0),
        .perf_grants1 (perf_grants1),
        .perf_stall   (perf_stall)
`endif
    );

    always #5 clock = ~clock;

    // Synchronous-read ROM with an enable-gated output register
    always @(posedge clock) begin
        if (rom_enable) rom_dout <= rom_mem[rom_address];
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_err = 0;
    int n_checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model state ----------------
    word_t exp_words[$];
    int    exp_addrs[$];
    word_t word_log[$];
    int    addr_log[$];
    int    grant_log[$];
    int    acc_cyc_log[$];
    int    pop_cyc_log[$];
    bit    acc_flag [2];
    bit    m_rr;
    int    outstanding;
    bit    stall_prev;
    word_t prev_word;
    bit    lat_pending;
    int    acc_cyc;

    int    g_m, s_m, l_m, a_m;
    logic  expg;
    word_t w_m, got_m;
    bit    pop_m;

    // Compare process: checks grants, ROM addresses, words, stalls and latency every cycle
    always @(negedge clock) begin
        if (reset) begin
            exp_words.delete();
            exp_addrs.delete();
            m_rr        = 1'b0;
            outstanding = 0;
            stall_prev  = 1'b0;
            lat_pending = 1'b0;
            acc_flag[0] = 1'b0;
            acc_flag[1] = 1'b0;
        end else begin
            if (req_ready != 2'b00) begin
                g_m = req_ready[1] ? 1 : 0;
                chk("ready_onehot", 32'(req_ready != 2'b11), 1);
                chk("grant_has_valid", 32'(req_valid[g_m]), 1);
                expg = req_valid[m_rr] ? m_rr : ~m_rr;
                chk("grant_rr", 32'(g_m), 32'(expg));
                chk("grant_when_idle", 32'(exp_words.size() == 0 && outstanding == 0), 1);
                s_m = int'(req_start[g_m*AW +: AW]);
                l_m = int'(req_len[g_m*LW +: LW]);
                if (s_m >= DEPTH) s_m = s_m - DEPTH;
                if (l_m > MAXB) l_m = MAXB;
                acc_flag[g_m] = 1'b1;
                grant_log.push_back(g_m);
                acc_cyc_log.push_back(cyc);
                m_rr = ~g_m[0];
                for (int k = 0; k < l_m; k++) begin
                    a_m = (s_m + k) % DEPTH;
                    exp_addrs.push_back(a_m);
                    w_m.id   = g_m[0];
                    w_m.data = rom_mem[a_m];
                    w_m.last = (k == l_m - 1);
                    exp_words.push_back(w_m);
                end
                if (l_m > 0) begin
                    lat_pending = 1'b1;
                    acc_cyc     = cyc;
                end
            end

            pop_m = out_valid && out_ready;

            if (rom_enable) begin
                if (exp_addrs.size() == 0) begin
                    chk("rom_read_unexpected", 1, 0);
                end else begin
                    chk("rom_address", 32'(rom_address), 32'(exp_addrs[0]));
                    void'(exp_addrs.pop_front());
                end
                addr_log.push_back(int'(rom_address));
            end
            chk("buffer_room", 32'(outstanding - int'(pop_m) + int'(rom_enable) <= 2), 1);

            if (pop_m) begin
                got_m.id   = out_id;
                got_m.data = out_data;
                got_m.last = out_last;
                if (exp_words.size() == 0) begin
                    chk("word_unexpected", 32'(got_m), 0);
                end else begin
                    chk("word_id", 32'(got_m.id), 32'(exp_words[0].id));
                    chk("word_data", 32'(got_m.data), 32'(exp_words[0].data));
                    chk("word_last", 32'(got_m.last), 32'(exp_words[0].last));
                    void'(exp_words.pop_front());
                end
                word_log.push_back(got_m);
                pop_cyc_log.push_back(cyc);
            end

            if (stall_prev) begin
                chk("stall_valid", 32'(out_valid), 1);
                chk("stall_hold", 32'({out_id, out_data, out_last}), 32'(prev_word));
            end

            if (lat_pending && cyc == acc_cyc + 2) chk("latency_early", 32'(out_valid), 0);
            if (lat_pending && cyc == acc_cyc + 3) begin
                chk("latency_first", 32'(out_valid), 1);
                chk("busy_in_burst", 32'(busy), 1);
                lat_pending = 1'b0;
            end

            outstanding = outstanding + int'(rom_enable) - int'(pop_m);
            stall_prev  = out_valid && !out_ready;
            prev_word   = {out_id, out_data, out_last};
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input int r, input int s, input int l);
        req_start[r*AW +: AW] = AW'(s);
        req_len[r*LW +: LW]   = LW'(l);
        req_valid[r]          = 1'b1;
    endtask

    task automatic req_once(input int r, input int s, input int l);
        int t;
        @(posedge clock); #1;
        set_req(r, s, l);
        t = 0;
        while (!acc_flag[r] && t < 200) begin
            @(posedge clock); #1;
            t++;
        end
        chk("req_accepted", 32'(acc_flag[r]), 1);
        acc_flag[r]  = 1'b0;
        req_valid[r] = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (!(exp_words.size() == 0 && exp_addrs.size() == 0 && !busy) && t < 600) begin
            @(posedge clock); #1;
            t++;
        end
        chk("idle_reached", 32'(t < 600), 1);
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic clear_logs();
        word_log.delete();
        addr_log.delete();
        grant_log.delete();
        acc_cyc_log.delete();
        pop_cyc_log.delete();
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        req_valid = 2'b00;
        reset     = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_out_data"}, 32'(out_data), 0);
        chk({tag, "_out_id"}, 32'(out_id), 0);
        chk({tag, "_out_last"}, 32'(out_last), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_rom_enable"}, 32'(rom_enable), 0);
        chk({tag, "_rom_address"}, 32'(rom_address), 0);
        chk({tag, "_req_ready"}, 32'(req_ready), 0);
    endtask

    logic [15:0] lit_data [4];
    int          lit_addr [4];
    int          wraps;
    int          t_w;

    initial begin
        // Reset state
        #12;
        chk_outputs_zero("reset");
        @(posedge clock); #1;
        reset = 1'b0;
        $display("phase reset: outputs checked while reset held");

        // Single burst: requester 0, start 3, length 4
        clear_logs();
        out_ready = 1'b1;
        req_once(0, 3, 4);
        wait_idle();
        lit_data = '{16'h02df, 16'h0fcf, 16'h0b4f, 16'h0fff};
        chk("single_count", 32'(word_log.size()), 4);
        for (int i = 0; i < 4 && i < word_log.size(); i++) begin
            chk("single_data", 32'(word_log[i].data), 32'(lit_data[i]));
            chk("single_id", 32'(word_log[i].id), 0);
            chk("single_last", 32'(word_log[i].last), 32'(i == 3));
        end
        if (word_log.size() == 4) begin
            chk("single_latency", 32'(pop_cyc_log[0] - acc_cyc_log[0]), 3);
            chk("single_rate", 32'(pop_cyc_log[3] - pop_cyc_log[0]), 3);
        end
        $display("txn single: req0 start=3 len=4 words=%0d", word_log.size());

        // Wrap: requester 1, start 18, length 4
        clear_logs();
        req_once(1, 18, 4);
        wait_idle();
        lit_data = '{16'hf3cf, 16'h1b4f, 16'h1fdf, 16'h1bff};
        lit_addr = '{18, 19, 0, 1};
        chk("wrap_count", 32'(word_log.size()), 4);
        for (int i = 0; i < 4 && i < word_log.size() && i < addr_log.size(); i++) begin
            chk("wrap_data", 32'(word_log[i].data), 32'(lit_data[i]));
            chk("wrap_id", 32'(word_log[i].id), 1);
            chk("wrap_addr", 32'(addr_log[i]), 32'(lit_addr[i]));
        end
        $display("txn wrap: req1 start=18 len=4 words=%0d", word_log.size());

        // Fairness: both requesters continuously valid with len=2 from reset
        do_reset();
        clear_logs();
        @(posedge clock); #1;
        set_req(0, 7, 2);
        set_req(1, 12, 2);
        for (int c = 0; c < 40; c++) begin
            @(posedge clock); #1;
            for (int r = 0; r < 2; r++) begin
                if (acc_flag[r]) begin
                    acc_flag[r] = 1'b0;
                    set_req(r, $urandom_range(0, 31), 2);
                end
            end
        end
        req_valid = 2'b00;
        acc_flag[0] = 1'b0;
        acc_flag[1] = 1'b0;
        wait_idle();
        chk("fair_grants", 32'(grant_log.size() >= 4), 1);
        chk("fair_words", 32'(word_log.size() >= 8), 1);
        if (grant_log.size() >= 4 && word_log.size() >= 8) begin
            for (int i = 0; i < 4; i++) chk("fair_order", 32'(grant_log[i]), 32'(i % 2));
            for (int i = 0; i < 8; i++) chk("fair_no_interleave", 32'(word_log[i].id), 32'((i / 2) % 2));
        end
        $display("txn fairness: grants=%0d words=%0d", grant_log.size(), word_log.size());

        // Backpressure: len=6, stall 5 cycles mid-burst then alternate
        clear_logs();
        out_ready = 1'b1;
        req_once(1, 10, 6);
        t_w = 0;
        while (word_log.size() < 2 && t_w < 50) begin
            @(posedge clock); #1;
            t_w++;
        end
        out_ready = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        t_w = 0;
        while (!(exp_words.size() == 0 && !busy) && t_w < 100) begin
            out_ready = ~out_ready;
            @(posedge clock); #1;
            t_w++;
        end
        out_ready = 1'b1;
        wait_idle();
        chk("bp_count", 32'(word_log.size()), 6);
        for (int i = 0; i < 6 && i < word_log.size(); i++)
            chk("bp_data", 32'(word_log[i].data), 32'(rom_mem[10 + i]));
        $display("txn backpressure: req1 start=10 len=6 words=%0d", word_log.size());

        // Length edges: len=0 toggles rr with no output; then both requesters
        clear_logs();
        req_once(0, 4, 0);
        repeat (6) @(posedge clock);
        #1;
        chk("len0_no_output", 32'(word_log.size()), 0);
        chk("len0_not_busy", 32'(busy), 0);
        set_req(0, 1, 3);
        set_req(1, 2, 3);
        t_w = 0;
        while (req_valid != 2'b00 && t_w < 60) begin
            @(posedge clock); #1;
            for (int r = 0; r < 2; r++) begin
                if (acc_flag[r]) begin
                    acc_flag[r]  = 1'b0;
                    req_valid[r] = 1'b0;
                end
            end
            t_w++;
        end
        wait_idle();
        chk("len0_grants", 32'(grant_log.size()), 3);
        if (grant_log.size() == 3) begin
            chk("len0_rr_toggle", 32'(grant_log[1]), 1);
            chk("len0_then_other", 32'(grant_log[2]), 0);
        end
        $display("txn len0: grants=%0d words=%0d", grant_log.size(), word_log.size());

        // len=40 clamps to 32 words, wrapping 19->0 exactly once from start 0
        clear_logs();
        req_once(0, 0, 40);
        wait_idle();
        chk("clamp_count", 32'(word_log.size()), 32);
        wraps = 0;
        for (int i = 1; i < addr_log.size(); i++)
            if (addr_log[i] == 0 && addr_log[i-1] == 19) wraps++;
        chk("clamp_wraps", 32'(wraps), 1);
        if (word_log.size() == 32) chk("clamp_last", 32'(word_log[31].last), 1);
        $display("txn clamp: req0 start=0 len=40 words=%0d wraps=%0d", word_log.size(), wraps);

        // Reset mid-burst on the 3rd output word
        clear_logs();
        req_once(0, 5, 8);
        t_w = 0;
        while (!(out_valid && word_log.size() == 2) && t_w < 50) begin
            @(posedge clock); #2;
            t_w++;
        end
        chk("midreset_reached", 32'(t_w < 50), 1);
        reset = 1'b1;
        #1;
        chk_outputs_zero("midreset");
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        clear_logs();
        req_once(0, 0, 2);
        wait_idle();
        chk("post_reset_count", 32'(word_log.size()), 2);
        if (word_log.size() == 2) begin
            chk("post_reset_w0", 32'(word_log[0].data), 32'h1fdf);
            chk("post_reset_w1", 32'(word_log[1].data), 32'h1bff);
            chk("post_reset_l0", 32'(word_log[0].last), 0);
            chk("post_reset_l1", 32'(word_log[1].last), 1);
        end
        $display("txn midreset: recovery burst words=%0d", word_log.size());

        // Randomized traffic against the model
        clear_logs();
        for (int c = 0; c < 3000; c++) begin
            @(posedge clock); #1;
            out_ready = ($urandom_range(0, 3) != 0);
            for (int r = 0; r < 2; r++) begin
                if (acc_flag[r]) begin
                    acc_flag[r]  = 1'b0;
                    req_valid[r] = 1'b0;
                end
                if (!req_valid[r] && $urandom_range(0, 2) == 0) begin
                    set_req(r, $urandom_range(0, 31),
                            ($urandom_range(0, 9) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 6));
                end
            end
        end
        req_valid = 2'b00;
        acc_flag[0] = 1'b0;
        acc_flag[1] = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        chk("random_drained", 32'(exp_words.size()), 0);
        $display("txn random: grants=%0d words=%0d", grant_log.size(), word_log.size());

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
